// File: rtl/bp_be_issue_queue_if.sv
// bp_be_issue_queue_if: enqueue, issue and commit-control signals of the BE issue queue.
interface bp_be_issue_queue_if #(
   parameter int els_p        = 16,
   parameter int data_width_p = 128
);
   localparam int ptr_width_lp = $clog2(els_p) + 1;
   logic [data_width_p-1:0] enq_data_i;
   logic                    enq_v_i;
   logic                    enq_ready_o;
   logic [data_width_p-1:0] iss_data_o;
   logic                    iss_v_o;
   logic                    iss_yumi_i;
   logic                    deq_i;
   logic                    roll_i;
   logic                    clr_i;
   logic                    full_o;
   logic                    empty_o;
   logic [ptr_width_lp-1:0] count_o;
   modport slave (
      input  enq_data_i, enq_v_i, iss_yumi_i, deq_i, roll_i, clr_i,
      output enq_ready_o, iss_data_o, iss_v_o, full_o, empty_o, count_o
   );
   modport master (
      output enq_data_i, enq_v_i, iss_yumi_i, deq_i, roll_i, clr_i,
      input  enq_ready_o, iss_data_o, iss_v_o, full_o, empty_o, count_o
   );
endinterface

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: circular queue with write, speculative-issue and commit pointers.
module bp_be_issue_queue #(
   parameter int els_p        = 16,
   parameter int data_width_p = 128
) (
   input  logic                clk_i,
   input  logic                reset_i,
   bp_be_issue_queue_if.slave  io
);
   localparam int idx_w_lp     = $clog2(els_p);
   localparam int ptr_width_lp = idx_w_lp + 1;
   typedef logic [ptr_width_lp-1:0] ptr_t;
   ptr_t r_wptr, r_rptr, r_cptr;
   ptr_t w_wptr_n, w_rptr_n, w_cptr_n;
   logic [data_width_p-1:0] r_mem [els_p];
   logic w_full, w_enq, w_yumi, w_deq;
   assign w_full         = (r_wptr[idx_w_lp-1:0] == r_cptr[idx_w_lp-1:0]) && (r_wptr[idx_w_lp] != r_cptr[idx_w_lp]);
   assign io.full_o      = w_full;
   assign io.empty_o     = r_wptr == r_cptr;
   assign io.count_o     = r_wptr - r_cptr;
   assign io.enq_ready_o = ~w_full & ~io.clr_i & ~io.roll_i;
   assign io.iss_v_o     = r_rptr != r_wptr;
   assign io.iss_data_o  = r_mem[r_rptr[idx_w_lp-1:0]];
   assign w_enq  = io.enq_v_i & io.enq_ready_o;
   assign w_yumi = io.iss_yumi_i & io.iss_v_o;
   // a commit can never pass the issue pointer
   assign w_deq  = io.deq_i & (r_cptr != r_rptr);
   always_comb begin
      w_cptr_n = r_cptr + ptr_t'(w_deq);
      w_rptr_n = (io.clr_i | io.roll_i) ? w_cptr_n : w_yumi ? r_rptr + ptr_t'(1) : r_rptr;
      w_wptr_n = io.clr_i ? w_cptr_n : w_enq ? r_wptr + ptr_t'(1) : r_wptr;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cptr <= '0;
      end else begin
         r_wptr <= w_wptr_n;
         r_rptr <= w_rptr_n;
         r_cptr <= w_cptr_n;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!reset_i && w_enq) r_mem[r_wptr[idx_w_lp-1:0]] <= io.enq_data_i;
   end
   a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i) io.deq_i |-> (r_cptr != r_rptr));
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) io.iss_yumi_i |-> io.iss_v_o);
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb_bp_be_issue_queue: scoreboard bench with a list-of-entries reference model, els_p=4.
module tb_bp_be_issue_queue;
   localparam int N = 4;
   localparam int W = 16;
   typedef struct packed {
      logic         v;
      logic [W-1:0] d;
      logic         full;
      logic         empty;
      logic [2:0]   cnt;
      logic         rdy;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   exp_t exp_q[$];
   logic [W-1:0] mq[$];
   int issued = 0;
   bp_be_issue_queue_if #(.els_p(N), .data_width_p(W)) bus ();
   bp_be_issue_queue #(.els_p(N), .data_width_p(W)) dut (.clk_i(clk), .reset_i(rst), .io(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("iss_v", 32'(bus.iss_v_o), 32'(e.v));
         if (e.v) chk("iss_data", 32'(bus.iss_data_o), 32'(e.d));
         chk("full", 32'(bus.full_o), 32'(e.full));
         chk("empty", 32'(bus.empty_o), 32'(e.empty));
         chk("count", 32'(bus.count_o), 32'(e.cnt));
         chk("enq_ready", 32'(bus.enq_ready_o), 32'(e.rdy));
      end
   end
   task automatic step(input logic e, input logic [W-1:0] d, input logic y, input logic dq,
                       input logic rl, input logic cl, input logic rs);
      exp_t x;
      logic acc_e, acc_y, acc_d;
      bus.enq_v_i = e;
      bus.enq_data_i = d;
      bus.iss_yumi_i = y;
      bus.deq_i = dq;
      bus.roll_i = rl;
      bus.clr_i = cl;
      rst = rs;
      x.v = issued < mq.size();
      x.d = x.v ? mq[issued] : '0;
      x.full = mq.size() == N;
      x.empty = mq.size() == 0;
      x.cnt = 3'(mq.size());
      x.rdy = mq.size() < N && !cl && !rl;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      if (rs) begin
         mq.delete();
         issued = 0;
      end else begin
         acc_e = e && mq.size() < N && !cl && !rl;
         acc_y = y && issued < mq.size();
         acc_d = dq && issued > 0;
         if (acc_d) begin
            void'(mq.pop_front());
            issued--;
         end
         if (cl) begin
            mq.delete();
            issued = 0;
         end else if (rl) issued = 0;
         else if (acc_y) issued++;
         if (acc_e) mq.push_back(d);
      end
   endtask
   task automatic idle();
      step(0, '0, 0, 0, 0, 0, 0);
   endtask
   task automatic enq(input logic [W-1:0] d);
      step(1, d, 0, 0, 0, 0, 0);
   endtask
   initial begin
      bus.enq_v_i = 0;
      bus.enq_data_i = '0;
      bus.iss_yumi_i = 0;
      bus.deq_i = 0;
      bus.roll_i = 0;
      bus.clr_i = 0;
      repeat (2) @(posedge clk);
      #1;
      idle();
      enq(16'hA); enq(16'hB); enq(16'hC); enq(16'hD);
      idle();
      step(0, '0, 1, 0, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0, 0);
      step(0, '0, 0, 0, 1, 0, 0);
      idle();
      step(0, '0, 0, 0, 0, 0, 1);
      enq(16'hA); enq(16'hB); enq(16'hC);
      repeat (3) step(0, '0, 1, 0, 0, 0, 0);
      step(0, '0, 0, 1, 0, 1, 0);
      idle();
      enq(16'h77);
      idle();
      for (int i = 0; i < 10; i++)
         step(1, 16'(16'h100 + i), issued < mq.size(), issued > 0, 0, 0, 0);
      idle();
      step(0, '0, 0, 0, 0, 0, 1);
      enq(16'h1); enq(16'h2); enq(16'h3); enq(16'h4);
      step(0, '0, 1, 0, 0, 0, 0);
      step(1, 16'h55, 1, 1, 1, 0, 1);
      idle();
      enq(16'h99);
      idle();
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 2) != 0, 16'($urandom), issued < mq.size() && $urandom_range(0, 1) == 1,
              issued > 0 && $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      idle();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
